// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder
//   Memory-side responder for the IF stage's fetch stream. It accepts a PC via
//   a valid/ready request, waits WAIT_STATES cycles, and returns the word read
//   from a word-addressed instruction store. Misaligned or out-of-range fetches
//   return NOP_INSTR with rsp_fault set. A flush drops any in-flight fetch. A
//   loader port writes the store at any time.
//
// Ports
//   clk                        clock, all logic on posedge
//   reset                      asynchronous active-low reset
//   req_valid/req_ready        fetch request handshake
//   req_addr[31:0]             fetch byte address (PC)
//   flush                      redirect, discards pending/in-flight response
//   rsp_valid/rsp_ready        response handshake
//   rsp_instr/rsp_addr[31:0]   response word and the byte address it belongs to
//   rsp_fault                  misaligned or out-of-range fetch
//   stall                      req_valid & !req_ready
//   ld_we/ld_addr/ld_data      loader write port (ld_addr[1:0] ignored)
//
// Optional build macro INSTR_FETCH_PERF_EN adds perf_fetches and
// perf_stall_cycles (wrapping 32-bit counters).

module instr_fetch_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_fault,
    output logic        stall,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] lat_addr;
    logic        accept;
    logic        load_rsp;

    logic [31:0] fetch_addr;
    logic [31:0] fetch_word_idx;
    logic        fetch_fault;
    logic [31:0] rd_word;
    logic [31:0] ld_word_idx;
    logic        unused_ld_bits;

    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Next-state and handshake outputs. Flush gates req_ready/rsp_valid
    // combinationally in the flush cycle and forces IDLE next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        load_rsp  = 1'b0;

        case (state)
            S_IDLE:  req_ready = !flush;
            S_RESP: begin
                rsp_valid = !flush;
                req_ready = rsp_ready && !flush;
            end
            default: ;
        endcase

        accept = req_valid && req_ready;

        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    // RESP without the consumer handshake simply holds.
                    if (state == S_IDLE || rsp_ready) begin
                        if (accept) begin
                            if (WAIT_STATES == 0) begin
                                state_nxt = S_RESP;
                                load_rsp  = 1'b1;
                            end else begin
                                state_nxt = S_WAIT;
                                cnt_nxt   = 4'(WAIT_STATES - 1);
                            end
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state_nxt = S_RESP;
                        load_rsp  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign stall = req_valid && !req_ready;

    // With zero wait states RESP is entered on the accepting edge, so the
    // address being latched is still on req_addr rather than in lat_addr.
    assign fetch_addr     = (state == S_WAIT) ? lat_addr : req_addr;
    assign fetch_word_idx = {2'b00, fetch_addr[31:2]};
    assign fetch_fault    = (fetch_addr[1:0] != 2'b00) ||
                            (fetch_word_idx >= 32'(DEPTH_WORDS));
    assign rd_word        = mem[fetch_addr[AW+1:2]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
            rsp_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_addr <= req_addr;
            end
            if (load_rsp) begin
                rsp_addr  <= fetch_addr;
                rsp_fault <= fetch_fault;
                rsp_instr <= fetch_fault ? NOP_INSTR : rd_word;
            end
        end
    end

    // Store: not reset. The read above is sampled on the same edge as this
    // write, so a same-edge write to the fetched word returns the old data.
    assign ld_word_idx    = {2'b00, ld_addr[31:2]};
    assign unused_ld_bits = &{1'b0, ld_addr[1:0]};

    always_ff @(posedge clk) begin
        if (ld_we && (ld_word_idx < 32'(DEPTH_WORDS))) begin
            mem[ld_addr[AW+1:2]] <= ld_data;
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetches      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                perf_fetches <= perf_fetches + 32'd1;
            end
            if (stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb_instr_fetch_responder
//   Directed bench for instr_fetch_responder. Three instances share clock,
//   reset and loader port: index 0 has WAIT_STATES=1, index 1 has
//   WAIT_STATES=0, index 2 has WAIT_STATES=3. Each has its own request and
//   response signals. Optional macro INSTR_FETCH_PERF_EN enables the
//   performance counter checks on instance 1.

module tb_instr_fetch_responder;

    localparam logic [31:0] W_ADDI5 = 32'h00500093; // word 4
    localparam logic [31:0] W_ADDI8 = 32'h00800113; // word 8
    localparam logic [31:0] W0      = 32'h11111111;
    localparam logic [31:0] W1      = 32'h22222222;
    localparam logic [31:0] W2      = 32'h33333333;
    localparam logic [31:0] W2_NEW  = 32'h44444444;
    localparam logic [31:0] W_LAST  = 32'hDEADBEEF; // word 1023
    localparam logic [31:0] NOP     = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic        rv  [3];
    logic        rr  [3];
    logic        fl  [3];
    logic [31:0] ra  [3];
    logic        rdy [3];
    logic        vld [3];
    logic        flt [3];
    logic        stl [3];
    logic [31:0] ins [3];
    logic [31:0] adr [3];
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] pf  [3];
    logic [31:0] ps  [3];
`endif

    int unsigned vectors;
    int unsigned miscompares;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        instr_fetch_responder #(
            .DEPTH_WORDS (1024),
            .WAIT_STATES (WS),
            .NOP_INSTR   (32'h00000013)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (rv[g]),
            .req_ready (rdy[g]),
            .req_addr  (ra[g]),
            .flush     (fl[g]),
            .rsp_valid (vld[g]),
            .rsp_ready (rr[g]),
            .rsp_instr (ins[g]),
            .rsp_addr  (adr[g]),
            .rsp_fault (flt[g]),
            .stall     (stl[g]),
            .ld_we     (ld_we),
            .ld_addr   (ld_addr),
            .ld_data   (ld_data)
`ifdef INSTR_FETCH_PERF_EN
            ,
            .perf_fetches      (pf[g]),
            .perf_stall_cycles (ps[g])
`endif
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the posedge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_we   = 1'b0;
    endtask

    task automatic chk_rsp(input int unsigned i, input string tag,
                           input logic [31:0] e_instr, input logic [31:0] e_addr,
                           input logic e_fault);
        chk({tag, ".valid"}, 32'(vld[i]), 32'd1);
        chk({tag, ".instr"}, ins[i], e_instr);
        chk({tag, ".addr"},  adr[i], e_addr);
        chk({tag, ".fault"}, 32'(flt[i]), 32'(e_fault));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b0;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; rr[i] = 1'b0; fl[i] = 1'b0; ra[i] = '0;
        end

        // ---- reset state ----
        tick(); settle();
        for (int i = 0; i < 3; i++) begin
            chk("reset.valid", 32'(vld[i]), 32'd0);
            chk("reset.instr", ins[i], 32'd0);
            chk("reset.addr",  adr[i], 32'd0);
            chk("reset.fault", 32'(flt[i]), 32'd0);
            chk("reset.ready", 32'(rdy[i]), 32'd1);
        end
        reset = 1'b1;

        // ---- program load (0x1000 is out of range and must not alias word 0) ----
        load(32'h10,  W_ADDI5);
        load(32'h0,   W0);
        load(32'h4,   W1);
        load(32'h8,   W2);
        load(32'h20,  W_ADDI8);
        load(32'hFFC, W_LAST);
        load(32'h1000, 32'hBAD0BAD0);

        // ---- WAIT_STATES=1: single fetch, 2-cycle latency ----
        rv[0] = 1'b1; ra[0] = 32'h10; rr[0] = 1'b1; settle();
        chk("ws1.accept_ready", 32'(rdy[0]), 32'd1);
        chk("ws1.accept_stall", 32'(stl[0]), 32'd0);
        tick(); rv[0] = 1'b0; settle();
        chk("ws1.lat1_valid", 32'(vld[0]), 32'd0);
        tick(); settle();
        chk_rsp(0, "ws1.lat2", W_ADDI5, 32'h10, 1'b0);
        tick(); settle();
        chk("ws1.idle_valid", 32'(vld[0]), 32'd0);

        // ---- WAIT_STATES=0: back-to-back fetches, one per cycle ----
        rr[1] = 1'b1; rv[1] = 1'b1; ra[1] = 32'h0; settle();
        chk("ws0.stall0", 32'(stl[1]), 32'd0);
        tick(); ra[1] = 32'h4; settle();
        chk_rsp(1, "ws0.r0", W0, 32'h0, 1'b0);
        chk("ws0.stall1", 32'(stl[1]), 32'd0);
        tick(); ra[1] = 32'h8; settle();
        chk_rsp(1, "ws0.r1", W1, 32'h4, 1'b0);
        chk("ws0.stall2", 32'(stl[1]), 32'd0);
        tick(); rv[1] = 1'b0; settle();
        chk_rsp(1, "ws0.r2", W2, 32'h8, 1'b0);
        tick(); settle();
        chk("ws0.idle_valid", 32'(vld[1]), 32'd0);

        // ---- backpressure: rsp_ready low for 3 cycles in RESP ----
        rv[1] = 1'b1; ra[1] = 32'h10; rr[1] = 1'b0;
        tick(); ra[1] = 32'h4; settle();
        for (int c = 0; c < 3; c++) begin
            chk_rsp(1, "bp.hold", W_ADDI5, 32'h10, 1'b0);
            chk("bp.ready", 32'(rdy[1]), 32'd0);
            chk("bp.stall", 32'(stl[1]), 32'd1);
            if (c < 2) begin
                tick(); settle();
            end
        end
        rr[1] = 1'b1; settle();
        chk("bp.release_ready", 32'(rdy[1]), 32'd1);
        chk("bp.release_stall", 32'(stl[1]), 32'd0);
        tick(); rv[1] = 1'b0; settle();
        chk_rsp(1, "bp.next", W1, 32'h4, 1'b0);
        tick(); settle();
        chk("bp.idle_valid", 32'(vld[1]), 32'd0);

        // ---- faults (misaligned, out of range) and last valid word ----
        rv[1] = 1'b1; ra[1] = 32'h6;
        tick(); ra[1] = 32'h1000; settle();
        chk_rsp(1, "flt.misaligned", NOP, 32'h6, 1'b1);
        tick(); ra[1] = 32'hFFC; settle();
        chk_rsp(1, "flt.range", NOP, 32'h1000, 1'b1);
        tick(); rv[1] = 1'b0; settle();
        chk_rsp(1, "flt.lastword", W_LAST, 32'hFFC, 1'b0);
        tick(); settle();
        chk("flt.idle_valid", 32'(vld[1]), 32'd0);

        // ---- read-before-write on the loader port ----
        rv[1] = 1'b1; ra[1] = 32'h8;
        ld_we = 1'b1; ld_addr = 32'h8; ld_data = W2_NEW;
        tick(); ld_we = 1'b0; settle();
        chk_rsp(1, "rbw.old", W2, 32'h8, 1'b0);
        tick(); rv[1] = 1'b0; settle();
        chk_rsp(1, "rbw.new", W2_NEW, 32'h8, 1'b0);
        tick(); settle();

        // ---- WAIT_STATES=3: flush drops in-flight fetch ----
        rr[2] = 1'b1; rv[2] = 1'b1; ra[2] = 32'h10;
        tick(); rv[2] = 1'b0; settle();
        chk("fl.wait1_valid", 32'(vld[2]), 32'd0);
        tick();
        fl[2] = 1'b1; rv[2] = 1'b1; ra[2] = 32'h20; settle();
        chk("fl.flush_ready", 32'(rdy[2]), 32'd0);
        chk("fl.flush_valid", 32'(vld[2]), 32'd0);
        chk("fl.flush_stall", 32'(stl[2]), 32'd1);
        tick(); fl[2] = 1'b0; settle();
        chk("fl.after_ready", 32'(rdy[2]), 32'd1);
        tick(); rv[2] = 1'b0; settle();
        for (int c = 1; c <= 3; c++) begin
            chk("fl.new_wait_valid", 32'(vld[2]), 32'd0);
            tick(); settle();
        end
        chk_rsp(2, "fl.new", W_ADDI8, 32'h20, 1'b0);
        tick(); settle();
        chk("fl.idle_valid", 32'(vld[2]), 32'd0);

        // ---- reset mid-WAIT ----
        rv[2] = 1'b1; ra[2] = 32'h0;
        tick(); rv[2] = 1'b0;
        tick();
        reset = 1'b0; settle();
        chk("rst.valid",  32'(vld[2]), 32'd0);
        chk("rst.instr",  ins[2], 32'd0);
        chk("rst.addr",   adr[2], 32'd0);
        chk("rst.fault",  32'(flt[2]), 32'd0);
        chk("rst.instr0", ins[0], 32'd0);
        chk("rst.addr1",  adr[1], 32'd0);
`ifdef INSTR_FETCH_PERF_EN
        chk("perf.rst_fetches", pf[1], 32'd0);
        chk("perf.rst_stalls",  ps[1], 32'd0);
`endif
        tick(); reset = 1'b1; settle();
        for (int c = 0; c < 5; c++) begin
            chk("rst.no_rsp_valid", 32'(vld[2]), 32'd0);
            chk("rst.idle_ready",   32'(rdy[2]), 32'd1);
            tick(); settle();
        end

        // ---- three handshakes with two stall cycles on instance 1 ----
        rr[1] = 1'b1; rv[1] = 1'b1; ra[1] = 32'h0;
        tick(); ra[1] = 32'h4; settle();
        chk_rsp(1, "pf.r0", W0, 32'h0, 1'b0);
        tick(); ra[1] = 32'h10; rr[1] = 1'b0; settle();
        chk_rsp(1, "pf.r1", W1, 32'h4, 1'b0);
        tick(); tick();
        rr[1] = 1'b1;
        tick(); rv[1] = 1'b0; settle();
        chk_rsp(1, "pf.r2", W_ADDI5, 32'h10, 1'b0);
        tick(); settle();
        chk("pf.idle_valid", 32'(vld[1]), 32'd0);
`ifdef INSTR_FETCH_PERF_EN
        chk("perf.fetches", pf[1], 32'd3);
        chk("perf.stalls",  ps[1], 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
